wq_mem_ctrl: RTL and testbench

Sequencer and arbiter for the 1024x128 Wq weight SRAM macro. Shares the single-port macro between a weight-load write requester and a Q-projection read requester using 2-way round-robin. Drives the active-low macro pins CEB, WEB and BWEB, and returns read data with fixed latency. Manages macro power (SLP light sleep, SD shutdown) from idle detection and an external shutdown request. BIST, RTSEL and WTSEL are tied off at the wrapper level and are not driven by this block.

---
 rtl/wq_mem_pkg.sv | 16 +
 rtl/wq_rr_arb2.sv | 28 ++
 rtl/wq_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wq_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wq_mem_pkg.sv
// Shared constants and power-state encoding for the Wq weight SRAM controller.
package wq_mem_pkg;

    localparam int WQ_ADDR_W = 10;   // 1024 words
    localparam int WQ_DATA_W = 128;  // word / bit-enable width
    localparam int RD_LAT    = 3;    // grant to rd_valid, in cycles
    localparam int WAKE_W    = 4;    // wake counter width, covers the longest wake time

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        SLEEP    = 2'd1,
        WAKE     = 2'd2,
        SHUTDOWN = 2'd3
    } pwr_state_e;

endpackage

// File: rtl/wq_rr_arb2.sv
// Two-requester round-robin arbiter: read vs write, combinational grants.
module wq_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rd_req,
    input  logic wr_req,
    output logic rd_gnt,
    output logic wr_gnt
);

    // Set when the most recent grant went to the read side.
    logic last_rd;

    // On contention the side that did not win last time gets the macro.
    always_comb begin
        rd_gnt = en && rd_req && (!wr_req || !last_rd);
        wr_gnt = en && wr_req && (!rd_req ||  last_rd);
    end

    // Pointer only moves on a grant; reset leaves read with priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_rd <= 1'b0;
        else if (rd_gnt) last_rd <= 1'b1;
        else if (wr_gnt) last_rd <= 1'b0;
    end

endmodule

// File: rtl/wq_mem_ctrl.sv
// Wq weight SRAM sequencer: arbitration, macro pin registers, read return
// pipeline and sleep/shutdown power sequencing.
module wq_mem_ctrl
    import wq_mem_pkg::*;
#(
    parameter int ADDR_W       = WQ_ADDR_W,
    parameter int DATA_W       = WQ_DATA_W,
    parameter int IDLE_W       = 8,
    parameter int SLP_WAKE_CYC = 2,
    parameter int SD_WAKE_CYC  = 8
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_bwe,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic [IDLE_W-1:0] cfg_idle_thr,
    input  logic              sd_req,
    output logic [1:0]        pwr_state,
    output logic              mem_ceb,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic [DATA_W-1:0] mem_bweb,
    input  logic [DATA_W-1:0] mem_q,
    output logic              mem_slp,
    output logic              mem_sd
);

    pwr_state_e         state;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [WAKE_W-1:0]  wake_cnt;
    logic [RD_LAT:1]    vld_pipe;
    logic               gnt_en;
    logic               idle_cyc;
    logic [IDLE_W:0]    idle_nxt;

    assign gnt_en    = (state == ACTIVE) && !sd_req;
    // Idle means nobody asking and nothing on the macro pins this cycle.
    assign idle_cyc  = !rd_req && !wr_req && mem_ceb;
    assign idle_nxt  = {1'b0, idle_cnt} + (IDLE_W+1)'(1);
    assign pwr_state = state;
    assign rd_valid  = vld_pipe[RD_LAT];

    wq_rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RSTB),
        .en     (gnt_en),
        .rd_req (rd_req),
        .wr_req (wr_req),
        .rd_gnt (rd_gnt),
        .wr_gnt (wr_gnt)
    );

    // Power FSM with idle and wake counters; SLP/SD are registered here.
    // sd_req blocks grants, so the cycle it is seen is the last pin cycle
    // of any access and shutdown can be entered on the next edge.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
            mem_slp  <= 1'b0;
            mem_sd   <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (sd_req) begin
                        state    <= SHUTDOWN;
                        mem_sd   <= 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cyc) begin
                        if ((cfg_idle_thr != '0) && (idle_nxt >= {1'b0, cfg_idle_thr})) begin
                            state    <= SLEEP;
                            mem_slp  <= 1'b1;
                            idle_cnt <= '0;
                        end else if (idle_cnt != '1) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                SLEEP: begin
                    if (sd_req) begin
                        state   <= SHUTDOWN;
                        mem_slp <= 1'b0;
                        mem_sd  <= 1'b1;
                    end else if (rd_req || wr_req) begin
                        state    <= WAKE;
                        mem_slp  <= 1'b0;
                        wake_cnt <= WAKE_W'(SLP_WAKE_CYC);
                    end
                end
                WAKE: begin
                    if (sd_req) begin
                        state  <= SHUTDOWN;
                        mem_sd <= 1'b1;
                    end else if (wake_cnt <= WAKE_W'(1)) begin
                        state    <= ACTIVE;
                        wake_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt - 1'b1;
                    end
                end
                SHUTDOWN: begin
                    if (!sd_req) begin
                        state    <= WAKE;
                        mem_sd   <= 1'b0;
                        wake_cnt <= WAKE_W'(SD_WAKE_CYC);
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    // Macro pin registers: a grant in cycle N shows on the pins in N+1.
    // Without a grant only CEB moves; the other pins keep their last value.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            mem_ceb  <= 1'b1;
            mem_web  <= 1'b1;
            mem_a    <= '0;
            mem_d    <= '0;
            mem_bweb <= '1;
        end else begin
            mem_ceb <= !(rd_gnt || wr_gnt);
            if (wr_gnt) begin
                mem_web  <= 1'b0;
                mem_a    <= wr_addr;
                mem_d    <= wr_data;
                mem_bweb <= ~wr_bwe;
            end else if (rd_gnt) begin
                mem_web  <= 1'b1;
                mem_a    <= rd_addr;
                mem_bweb <= '1;
            end
        end
    end

    // Read return: valid bits ride a shift register, Q captured one stage
    // before the valid pulse so data and valid line up.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            vld_pipe <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:1], rd_gnt};
            if (vld_pipe[RD_LAT-1]) rd_data <= mem_q;
        end
    end

endmodule

// File: tb/tb_wq_mem_ctrl.sv
// Self-checking bench for wq_mem_ctrl: directed power/arbitration scenarios
// followed by random traffic against a request-level reference memory.
module tb_wq_mem_ctrl;

    localparam int AW = 10;
    localparam int DW = 128;

    logic          CLK, RSTB;
    logic          wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr, mem_a;
    logic [DW-1:0] wr_data, wr_bwe, rd_data, mem_d, mem_bweb, mem_q;
    logic [7:0]    cfg_idle_thr;
    logic          sd_req, mem_ceb, mem_web, mem_slp, mem_sd;
    logic [1:0]    pwr_state;

    wq_mem_ctrl dut (
        .CLK(CLK), .RSTB(RSTB),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bwe(wr_bwe), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .cfg_idle_thr(cfg_idle_thr), .sd_req(sd_req), .pwr_state(pwr_state),
        .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_d(mem_d),
        .mem_bweb(mem_bweb), .mem_q(mem_q), .mem_slp(mem_slp), .mem_sd(mem_sd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural single-port macro: samples pins at the clock edge, Q registered.
    logic [DW-1:0] marr [1024];
    initial for (int i = 0; i < 1024; i++) marr[i] = '0;
    always @(posedge CLK) begin
        if (!mem_ceb) begin
            if (!mem_web) marr[mem_a] <= (marr[mem_a] & mem_bweb) | (mem_d & ~mem_bweb);
            else          mem_q <= marr[mem_a];
        end
    end

    typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
    rd_exp_t rq[$];
    logic [DW-1:0] ref_mem [1024];

    int total, bad, cyc;
    logic exp_ceb, exp_web, exp_wr_pin;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_bweb;
    logic s_rd_gnt, s_wr_gnt, s_rd_valid, s_slp, s_sd, prev_slp, prev_sd;
    logic [DW-1:0] s_rd_data;
    logic [1:0] pwr_at_slp_fall;
    int rd_gnt_cyc, wr_gnt_cyc, slp_rise_cyc, slp_fall_cyc, sd_rise_cyc, sd_fall_cyc;
    bit chk_arb, last_rd, exp_r, exp_w;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rst_exp();
        exp_ceb = 1'b1; exp_web = 1'b1; exp_a = '0; exp_d = '0; exp_bweb = '1;
        exp_wr_pin = 1'b0; rq.delete(); last_rd = 1'b0;
        prev_slp = 1'b0; prev_sd = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, check pins and read
    // returns against the model, then advance to just after the rising edge.
    task automatic mon();
        bit ev;
        @(negedge CLK);
        cyc++;
        chk("pin_ceb", mem_ceb, exp_ceb);
        chk("pin_web", mem_web, exp_web);
        chk("pin_a", mem_a, exp_a);
        chk("pin_bweb", mem_bweb, exp_bweb);
        if (exp_wr_pin) chk("pin_d", mem_d, exp_d);
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rd_valid", rd_valid, ev);
        if (ev) begin
            chk("rd_data", rd_data, rq[0].data);
            void'(rq.pop_front());
        end
        s_rd_gnt = rd_gnt; s_wr_gnt = wr_gnt; s_rd_valid = rd_valid; s_rd_data = rd_data;
        s_slp = mem_slp; s_sd = mem_sd;
        if (s_slp && !prev_slp) slp_rise_cyc = cyc;
        if (!s_slp && prev_slp) begin slp_fall_cyc = cyc; pwr_at_slp_fall = pwr_state; end
        if (s_sd && !prev_sd) sd_rise_cyc = cyc;
        if (!s_sd && prev_sd) sd_fall_cyc = cyc;
        prev_slp = s_slp; prev_sd = s_sd;
        if (chk_arb) begin
            // Lone requester wins; on contention the loser of last time wins.
            if (rd_req && wr_req) begin exp_r = !last_rd; exp_w = last_rd; end
            else begin exp_r = rd_req; exp_w = wr_req; end
            chk("arb_rd", s_rd_gnt, exp_r);
            chk("arb_wr", s_wr_gnt, exp_w);
        end
        exp_ceb = !(s_rd_gnt || s_wr_gnt);
        exp_wr_pin = s_wr_gnt;
        if (s_wr_gnt) begin
            exp_web = 1'b0; exp_a = wr_addr; exp_d = wr_data; exp_bweb = ~wr_bwe;
            ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_bwe) | (wr_data & wr_bwe);
            last_rd = 1'b0; wr_gnt_cyc = cyc;
        end else if (s_rd_gnt) begin
            exp_web = 1'b1; exp_a = rd_addr; exp_bweb = '1;
            rq.push_back('{cyc + 3, ref_mem[rd_addr]});
            last_rd = 1'b1; rd_gnt_cyc = cyc;
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be);
        wr_addr = a; wr_data = d; wr_bwe = be; wr_req = 1'b1;
        for (int k = 0; k < 40; k++) begin mon(); if (s_wr_gnt) break; end
        chk("wr_gnt_timeout", s_wr_gnt, 1'b1);
        wr_req = 1'b0;
    endtask

    task automatic do_rd(input logic [AW-1:0] a);
        rd_addr = a; rd_req = 1'b1;
        for (int k = 0; k < 40; k++) begin mon(); if (s_rd_gnt) break; end
        chk("rd_gnt_timeout", s_rd_gnt, 1'b1);
        rd_req = 1'b0;
    endtask

    task automatic wait_rd_valid();
        for (int k = 0; k < 20; k++) begin mon(); if (s_rd_valid) break; end
        chk("rd_valid_timeout", s_rd_valid, 1'b1);
        chk("rd_latency", 128'(cyc - rd_gnt_cyc), 128'd3);
    endtask

    task automatic do_reset();
        RSTB = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        #1;
        chk("rst_ceb", mem_ceb, 1'b1);
        chk("rst_web", mem_web, 1'b1);
        chk("rst_bweb", mem_bweb, {DW{1'b1}});
        chk("rst_a", mem_a, '0);
        chk("rst_d", mem_d, '0);
        chk("rst_slp", mem_slp, 1'b0);
        chk("rst_sd", mem_sd, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_pwr", pwr_state, 2'd0);
        set_rst_exp();
        repeat (2) @(posedge CLK);
        #1 RSTB = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; chk_arb = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        RSTB = 1'b1; wr_req = 1'b0; rd_req = 1'b0; sd_req = 1'b0; cfg_idle_thr = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_bwe = '0;
        set_rst_exp();
        #2;
        do_reset();

        // Full write then read back.
        do_wr(10'h005, {16{8'hA5}}, {DW{1'b1}});
        do_rd(10'h005);
        wait_rd_valid();
        chk("wr_rd_data", s_rd_data, {16{8'hA5}});

        // Partial write onto a zeroed word.
        do_wr(10'h010, '0, {DW{1'b1}});
        do_wr(10'h010, {DW{1'b1}}, 128'hFF);
        chk("bweb_partial", mem_bweb, {{120{1'b1}}, 8'h00});
        do_rd(10'h010);
        wait_rd_valid();
        chk("partial_data", s_rd_data, 128'hFF);
        repeat (2) mon();

        // Contention straight after reset: strict R,W,R,W alternation.
        do_reset();
        chk_arb = 1'b1;
        rd_addr = 10'h005; wr_addr = 10'h030; wr_data = {4{32'h1234_5678}}; wr_bwe = {DW{1'b1}};
        rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mon();
            chk("cont_rd", s_rd_gnt, (i % 2) == 0);
            chk("cont_wr", s_wr_gnt, (i % 2) == 1);
            if (i > 0) chk("cont_b2b_ceb", mem_ceb, 1'b0);
        end
        rd_req = 1'b0; wr_req = 1'b0; chk_arb = 1'b0;
        repeat (4) mon();

        // Idle into sleep, then wake on a read.
        cfg_idle_thr = 8'd4;
        do_rd(10'h030);
        for (int k = 0; k < 20; k++) begin mon(); if (s_slp) break; end
        chk("slp_entry", 128'(slp_rise_cyc - rd_gnt_cyc), 128'd6);
        chk("slp_pwr", pwr_state, 2'd1);
        do_rd(10'h005);
        chk("wake_pwr", pwr_at_slp_fall, 2'd2);
        chk("slp_wake_lat", 128'(rd_gnt_cyc - slp_fall_cyc), 128'd2);
        cfg_idle_thr = '0;
        repeat (4) mon();

        // Shutdown right behind a read; requests wait through it.
        do_rd(10'h010);
        sd_req = 1'b1;
        wr_addr = 10'h040; wr_data = {4{32'hCAFE_F00D}}; wr_bwe = {DW{1'b1}};
        rd_addr = 10'h040;
        mon();
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mon();
            chk("sd_no_gnt", s_rd_gnt | s_wr_gnt, 1'b0);
        end
        chk("sd_rise", 128'(sd_rise_cyc - rd_gnt_cyc), 128'd2);
        chk("sd_pin", mem_sd, 1'b1);
        chk("sd_pwr", pwr_state, 2'd3);
        sd_req = 1'b0;
        for (int k = 0; k < 30; k++) begin mon(); if (s_rd_gnt || s_wr_gnt) break; end
        chk("sd_first_wr", s_wr_gnt, 1'b1);
        chk("sd_wake_lat", 128'(wr_gnt_cyc - sd_fall_cyc), 128'd8);
        wr_req = 1'b0;
        mon();
        chk("sd_then_rd", s_rd_gnt, 1'b1);
        rd_req = 1'b0;
        repeat (4) mon();

        // Reset one cycle after a read grant: no stale rd_valid, read favoured.
        do_rd(10'h040);
        do_reset();
        repeat (5) mon();
        rd_addr = 10'h005; wr_addr = 10'h050; rd_req = 1'b1; wr_req = 1'b1;
        mon();
        chk("post_rst_rd_first", s_rd_gnt, 1'b1);
        rd_req = 1'b0;
        mon();
        chk("post_rst_wr_next", s_wr_gnt, 1'b1);
        wr_req = 1'b0;
        repeat (4) mon();

        // Random read/write traffic, always active.
        chk_arb = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!rd_req && $urandom_range(1) == 1) begin
                rd_addr = 10'($urandom_range(15)); rd_req = 1'b1;
            end
            if (!wr_req && $urandom_range(1) == 1) begin
                wr_addr = 10'($urandom_range(15));
                wr_data = {$urandom, $urandom, $urandom, $urandom};
                wr_bwe  = {$urandom, $urandom, $urandom, $urandom};
                wr_req  = 1'b1;
            end
            mon();
            if (s_rd_gnt) rd_req = 1'b0;
            if (s_wr_gnt) wr_req = 1'b0;
        end
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (6) mon();
        chk("rq_drained", 128'(rq.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
